// File: rtl/period_pkg.sv
// Shared types and default constants for the period measurement stage.
package period_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT1 = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int unsigned DEF_CLK_PER_US = 50;
    localparam int unsigned DEF_W          = 20;
    localparam int unsigned DEF_MAX_US     = 1_000_000;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus delay flop; rise pulses one cycle per 0->1.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic dly_q,   dly_d;

    always_comb begin
        sync1_d = d_async;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
        end
    end

    assign rise = sync2_q & ~dly_q;

endmodule

// File: rtl/period_counter.sv
// Measures one rise-to-rise period of signal_in in microseconds,
// with a timeout for slow or stuck inputs.
module period_counter
    import period_pkg::*;
#(
    parameter int unsigned CLK_PER_US = DEF_CLK_PER_US,
    parameter int unsigned W          = DEF_W,
    parameter int unsigned MAX_US     = DEF_MAX_US
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         signal_in,
    output logic         ready,
    output logic [W-1:0] period_us,
    output logic         timeout,
    output logic         done_tick
);

    localparam int unsigned TW =
        (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_PER_US - 1);
    localparam logic [W-1:0]  MAX_CNT   = W'(MAX_US);

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q,  tick_d;
    logic [W-1:0]  us_q,    us_d;
    logic [W-1:0]  per_q,   per_d;
    logic          to_q,    to_d;

    logic rise;
    logic us_tick;
    logic at_max;

    edge_sync u_edge_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (signal_in),
        .rise    (rise)
    );

    assign us_tick = (tick_q == TICK_LAST);
    assign at_max  = (us_q == MAX_CNT);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        us_d    = us_q;
        per_d   = per_q;
        to_d    = to_q;
        unique case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (start) begin
                    state_d = S_WAIT1;
                    us_d    = '0;
                end
            end
            S_WAIT1: begin
                tick_d = us_tick ? '0 : tick_q + 1'b1;
                if (rise) begin
                    state_d = S_COUNT;
                    tick_d  = '0;
                    us_d    = '0;
                end else if (us_tick) begin
                    if (at_max) begin
                        state_d = S_DONE;
                        per_d   = '0;
                        to_d    = 1'b1;
                    end else begin
                        us_d = us_q + 1'b1;
                    end
                end
            end
            S_COUNT: begin
                tick_d = us_tick ? '0 : tick_q + 1'b1;
                if (rise) begin
                    // a tick landing on the closing edge still counts
                    state_d = S_DONE;
                    per_d   = (us_tick && !at_max) ? us_q + 1'b1 : us_q;
                    to_d    = 1'b0;
                end else if (us_tick) begin
                    if (at_max) begin
                        state_d = S_DONE;
                        per_d   = '0;
                        to_d    = 1'b1;
                    end else begin
                        us_d = us_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            us_q    <= '0;
            per_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            us_q    <= us_d;
            per_q   <= per_d;
            to_q    <= to_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done_tick = (state_q == S_DONE);
    assign period_us = per_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_period_counter.sv
// Directed bench for period_counter with a scaled-down timebase.
module tb_period_counter;

    localparam int C    = 4;
    localparam int W    = 20;
    localparam int MAXU = 200;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sig = 1'b0;
    logic         ready;
    logic [W-1:0] period_us;
    logic         timeout;
    logic         done_tick;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int half    = 100;
    bit gen_en  = 1'b0;
    int gcnt    = 0;

    period_counter #(
        .CLK_PER_US (C),
        .W          (W),
        .MAX_US     (MAXU)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signal_in (sig),
        .ready     (ready),
        .period_us (period_us),
        .timeout   (timeout),
        .done_tick (done_tick)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #2;
        if (gen_en) begin
            gcnt++;
            if (gcnt >= half) begin
                gcnt = 0;
                sig  = ~sig;
            end
        end else begin
            gcnt = 0;
        end
    end

    always @(negedge clk)
        if (done_tick === 1'b1) n_done++;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick(1);
            if (done_tick === 1'b1) got = 1'b1;
        end
    endtask

    task automatic measure(input string tag, input int h,
                           input int exp_p, input bit exp_to,
                           input bit start_on_done);
        bit got;
        gen_en = 1'b0;
        sig    = 1'b0;
        half   = h;
        tick(2);
        gen_en = 1'b1;
        pulse_start();
        wait_done(6 * h + 2000, got);
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_per"}, 32'(period_us), 32'(exp_p));
        check({tag, "_to"}, 32'(timeout), 32'(exp_to));
        if (start_on_done) start = 1'b1;
        tick(1);
        start = 1'b0;
        check({tag, "_rdy"}, 32'(ready), 32'd1);
        if (start_on_done) begin
            tick(1);
            check({tag, "_nostart"}, 32'(ready), 32'd1);
        end
    endtask

    initial begin
        bit got;
        int d0;
        tick(3);
        check("rst_rdy", 32'(ready), 32'd1);
        check("rst_per", 32'(period_us), 32'd0);
        check("rst_to", 32'(timeout), 32'd0);
        check("rst_done", 32'(done_tick), 32'd0);
        rst_n = 1'b1;
        tick(2);

        measure("p200", 100, 50, 1'b0, 1'b1);
        measure("p4", 2, 1, 1'b0, 1'b0);
        measure("p6", 3, 1, 1'b0, 1'b0);
        measure("p10", 5, 2, 1'b0, 1'b0);
        measure("p300", 150, 75, 1'b0, 1'b0);

        // input held low: no result before the limit, timeout after
        gen_en = 1'b0;
        sig    = 1'b0;
        tick(2);
        pulse_start();
        wait_done(800, got);
        check("low_early", 32'(got), 32'd0);
        wait_done(20, got);
        check("low_done", 32'(got), 32'd1);
        check("low_per", 32'(period_us), 32'd0);
        check("low_to", 32'(timeout), 32'd1);
        tick(1);

        measure("p800", 400, 200, 1'b0, 1'b0);
        measure("p820", 410, 0, 1'b1, 1'b0);

        // extra starts while busy are dropped
        gen_en = 1'b0;
        sig    = 1'b0;
        half   = 100;
        tick(2);
        gen_en = 1'b1;
        d0 = n_done;
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            start = (i == 20 || i == 120 || i == 180 || i == 250);
            tick(1);
            if (done_tick === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        check("spam_done", 32'(got), 32'd1);
        check("spam_per", 32'(period_us), 32'd50);
        tick(20);
        check("spam_cnt", 32'(n_done - d0), 32'd1);
        check("spam_rdy", 32'(ready), 32'd1);

        // one rise then stuck high
        gen_en = 1'b0;
        sig    = 1'b0;
        tick(2);
        pulse_start();
        tick(10);
        sig = 1'b1;
        wait_done(2000, got);
        check("high_done", 32'(got), 32'd1);
        check("high_per", 32'(period_us), 32'd0);
        check("high_to", 32'(timeout), 32'd1);
        tick(1);

        measure("pre_rst", 100, 50, 1'b0, 1'b0);

        // async reset in the middle of COUNT
        gen_en = 1'b0;
        sig    = 1'b0;
        tick(2);
        pulse_start();
        tick(10);
        sig = 1'b1;
        tick(100);
        d0 = n_done;
        rst_n = 1'b0;
        #1;
        check("mid_rdy", 32'(ready), 32'd1);
        check("mid_per", 32'(period_us), 32'd0);
        check("mid_to", 32'(timeout), 32'd0);
        check("mid_done", 32'(done_tick), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("mid_nodone", 32'(n_done - d0), 32'd0);

        measure("post_rst", 150, 75, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
